// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM 1:4 receive demultiplexer.
package tdm_pkg;

  // Number of output lanes in one TDM frame.
  localparam int LANES  = 4;
  // Width of the slot (lane index) counter.
  localparam int SLOT_W = 2;

  // Frame alignment state.
  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/demux_dec2to4.sv
// 2-to-4 one-hot decoder with enable; selects which lane register is written.
module demux_dec2to4
  import tdm_pkg::*;
(
  input  logic              en_i,
  input  logic [SLOT_W-1:0] sel_i,
  output logic [LANES-1:0]  onehot_o
);

  // Decode the selected lane into a one-hot write strobe, all-zero when idle.
  always_comb begin
    onehot_o = 4'b0000;
    if (en_i) begin
      case (sel_i)
        2'd0:    onehot_o = 4'b0001;
        2'd1:    onehot_o = 4'b0010;
        2'd2:    onehot_o = 4'b0100;
        2'd3:    onehot_o = 4'b1000;
        default: onehot_o = 4'b0000;
      endcase
    end else begin
      onehot_o = 4'b0000;
    end
  end

endmodule

// File: rtl/tdm_demux1to4.sv
// TDM 1:4 demultiplexer: aligns to frame_sync on lane 0, distributes samples
// to held per-lane registers, and reports frame completion and misalignment.
module tdm_demux1to4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   frame_sync,
  output logic [LANES*WIDTH-1:0] dout,
  output logic [LANES-1:0]       dout_valid,
  output logic                   frame_done,
  output logic                   sync_err,
  output logic                   locked,
  output logic [SLOT_W-1:0]      slot
);

  state_e                 state_q, state_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [LANES*WIDTH-1:0] dout_q;
  logic [LANES-1:0]       dout_valid_q;
  logic                   frame_done_q, frame_done_d;
  logic                   sync_err_q, sync_err_d;

  logic                   write_s;
  logic [SLOT_W-1:0]      wsel_s;
  logic [LANES-1:0]       lane_we_s;

  // Next-state logic: decide whether and where the current sample is written.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    write_s      = 1'b0;
    wsel_s       = slot_q;
    sync_err_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      HUNT: begin
        // Samples before the first marker carry no lane identity; drop them.
        if (din_valid && frame_sync) begin
          write_s = 1'b1;
          wsel_s  = 2'd0;
          slot_d  = 2'd1;
          state_d = LOCKED;
        end else begin
          state_d = HUNT;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          if (frame_sync && (slot_q != 2'd0)) begin
            // Marker mid-frame: abandon the partial frame and realign.
            sync_err_d = 1'b1;
            write_s    = 1'b1;
            wsel_s     = 2'd0;
            slot_d     = 2'd1;
          end else begin
            write_s      = 1'b1;
            wsel_s       = slot_q;
            slot_d       = slot_q + 2'd1;
            frame_done_d = (slot_q == 2'd3);
          end
        end else begin
          slot_d = slot_q;
        end
      end
      default: begin
        state_d = HUNT;
        slot_d  = 2'd0;
      end
    endcase
  end

  demux_dec2to4 u_dec (
    .en_i     (write_s),
    .sel_i    (wsel_s),
    .onehot_o (lane_we_s)
  );

  // State, slot counter, lane registers and single-cycle event strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= 2'd0;
      dout_q       <= '0;
      dout_valid_q <= 4'b0000;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      dout_valid_q <= lane_we_s;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      for (int i = 0; i < LANES; i++) begin
        if (lane_we_s[i]) begin
          dout_q[i*WIDTH +: WIDTH] <= din;
        end
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCKED);
  assign slot       = slot_q;

endmodule

// File: tb/tb_tdm_demux1to4.sv
// Directed self-checking bench for tdm_demux1to4 (WIDTH=8).
module tb_tdm_demux1to4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_valid;
  logic        frame_sync;
  logic [31:0] dout;
  logic [3:0]  dout_valid;
  logic        frame_done;
  logic        sync_err;
  logic        locked;
  logic [1:0]  slot;

  int n_cmp  = 0;
  int n_fail = 0;

  // Observed outputs packed as {dout, dout_valid, frame_done, sync_err, locked, slot}.
  logic [40:0] obs;
  assign obs = {dout, dout_valid, frame_done, sync_err, locked, slot};

  tdm_demux1to4 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked),
    .slot       (slot)
  );

  always #5 clk = ~clk;

  // Apply one input vector, then let one rising edge pass and settle.
  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [40:0] exp;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, 8'h5A);
    exp = {32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", obs, exp);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_hunt_frame();
    logic [7:0]  d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [31:0] m = 32'h0;
    logic [40:0] exp;
    drive(1'b1, 1'b0, 8'hAA);
    exp = {32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL hunt_drop: got %h want %h", obs, exp);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0), d[i]);
      m[i*8 +: 8] = d[i];
      exp = {m, 4'(4'b0001 << i), (i == 3), 1'b0, 1'b1, 2'((i + 1) % 4)};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL hunt_frame lane%0d: got %h want %h", i, obs, exp);
      end
    end
    n_cmp++;
    if (dout !== 32'h44332211) begin
      n_fail++;
      $display("FAIL hunt_frame dout: got %h want 44332211", dout);
    end
    drive(1'b0, 1'b0, 8'h00);
    exp = {32'h44332211, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL hunt_frame idle: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_gaps();
    logic [7:0]  d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [40:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0), d[i]);
      exp = {32'h44332211, 4'(4'b0001 << i), (i == 3), 1'b0, 1'b1, 2'((i + 1) % 4)};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL gaps lane%0d: got %h want %h", i, obs, exp);
      end
      for (int g = 0; g < 3; g++) begin
        // Idle cycles carry junk data and a stray marker that must be ignored.
        drive(1'b0, 1'b1, 8'hEE);
        exp = {32'h44332211, 4'b0000, 1'b0, 1'b0, 1'b1, 2'((i + 1) % 4)};
        n_cmp++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL gaps idle%0d after lane%0d: got %h want %h", g, i, obs, exp);
        end
      end
    end
  endtask

  task automatic test_resync();
    logic [7:0]  d [3] = '{8'h66, 8'h77, 8'h88};
    logic [31:0] m;
    logic [40:0] exp;
    drive(1'b1, 1'b1, 8'h11);
    drive(1'b1, 1'b0, 8'h22);
    drive(1'b1, 1'b1, 8'h55);
    exp = {32'h44332255, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd1};
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL resync err: got %h want %h", obs, exp);
    end
    m = 32'h44332255;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, d[i]);
      m[(i+1)*8 +: 8] = d[i];
      exp = {m, 4'(4'b0010 << i), (i == 2), 1'b0, 1'b1, 2'((i + 2) % 4)};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL resync lane%0d: got %h want %h", i + 1, obs, exp);
      end
    end
    n_cmp++;
    if (dout !== 32'h88776655) begin
      n_fail++;
      $display("FAIL resync dout: got %h want 88776655", dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] m = 32'h88776655;
    logic [40:0] exp;
    int          n_done = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0), 8'(i + 1));
      m[(i % 4)*8 +: 8] = 8'(i + 1);
      if (frame_done) n_done++;
      exp = {m, 4'(4'b0001 << (i % 4)), ((i % 4) == 3), 1'b0, 1'b1, 2'((i + 1) % 4)};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL b2b sample%0d: got %h want %h", i, obs, exp);
      end
    end
    n_cmp++;
    if (n_done !== 2) begin
      n_fail++;
      $display("FAIL b2b frame_done count: got %0d want 2", n_done);
    end
    n_cmp++;
    if ({dout, slot} !== {32'h08070605, 2'd0}) begin
      n_fail++;
      $display("FAIL b2b final: got dout=%h slot=%0d want 08070605 slot=0", dout, slot);
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_midframe_reset();
    logic [40:0] exp;
    drive(1'b1, 1'b1, 8'hAA);
    drive(1'b1, 1'b0, 8'hBB);
    exp = {32'h0807BBAA, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2};
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL mid_reset pre: got %h want %h", obs, exp);
    end
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'hCC);
    exp = {32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL mid_reset clear: got %h want %h", obs, exp);
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'hCC);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL mid_reset hunt_drop: got %h want %h", obs, exp);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst_n      = 1'b0;
    din        = 8'h00;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    test_reset();
    test_hunt_frame();
    test_gaps();
    test_resync();
    test_back_to_back();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
